round_arbiter: RTL and testbench

ROUND_ARBITER -- requirements
Module: round_arbiter

---
 rtl/round_arbiter_if.sv | 45 ++++
 rtl/round_arbiter.sv | 108 ++++++++++
 tb/tb_round_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/round_arbiter_if.sv
// Request/grant, shared-rounder and result bundle for round_arbiter.
// master: requesters plus the shared rounder; slave: the arbiter itself.
interface round_arbiter_if #(
  parameter int Significant_WD  = 23,
  parameter int roundmodeReg_WD = 2
);
  logic                        add_req;
  logic [Significant_WD+3:0]   add_Min;
  logic                        add_sign;
  logic                        mul_req;
  logic [Significant_WD+3:0]   mul_Min;
  logic                        mul_sign;
  logic [roundmodeReg_WD-1:0]  roundMode;
  logic                        add_gnt;
  logic                        mul_gnt;
  logic                        add_done;
  logic                        mul_done;
  logic [Significant_WD+3:0]   rnd_Min;
  logic [roundmodeReg_WD-1:0]  rnd_roundMode;
  logic                        rnd_sign;
  logic [Significant_WD-1:0]   rnd_MOut;
  logic                        rnd_ovf;
  logic                        rnd_inexact;
  logic [Significant_WD-1:0]   MOut;
  logic                        ovf_rnd;
  logic                        inexact_flag;
  logic                        owner;
  logic                        busy;
  logic                        clr_sticky;
  logic                        inexact_sticky;

  modport master (
    output add_req, add_Min, add_sign, mul_req, mul_Min, mul_sign, roundMode,
           rnd_MOut, rnd_ovf, rnd_inexact, clr_sticky,
    input  add_gnt, mul_gnt, add_done, mul_done, rnd_Min, rnd_roundMode,
           rnd_sign, MOut, ovf_rnd, inexact_flag, owner, busy, inexact_sticky
  );

  modport slave (
    input  add_req, add_Min, add_sign, mul_req, mul_Min, mul_sign, roundMode,
           rnd_MOut, rnd_ovf, rnd_inexact, clr_sticky,
    output add_gnt, mul_gnt, add_done, mul_done, rnd_Min, rnd_roundMode,
           rnd_sign, MOut, ovf_rnd, inexact_flag, owner, busy, inexact_sticky
  );
endinterface

// File: rtl/round_arbiter.sv
// Shares one combinational rounder between the adder and the multiplier.
// One operation takes three cycles: grant, capture, done.
//
// state | meaning
// IDLE  | waiting; a request here is granted and its operand registered
// ROUND | grant pulse; shared rounder result captured at the end
// DONE  | done pulse to the owner; back to IDLE
module round_arbiter #(
  parameter int Significant_WD  = 23,
  parameter int roundmodeReg_WD = 2
) (
  input  logic           CLK,
  input  logic           RST,
  round_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic                       any_req;
  logic                       pick;
  logic                       cur;
  logic                       last_grant;
  logic [Significant_WD+3:0]  sel_min;
  logic                       sel_sign;
  logic [roundmodeReg_WD-1:0] sel_mode;

  assign any_req  = bus.add_req | bus.mul_req;
  assign sel_mode = bus.roundMode;

  // Round-robin pick: on a tie the requester opposite the last grant wins.
  always_comb begin
    pick = 1'b0;
    if (bus.add_req && bus.mul_req) begin
      pick = ~last_grant;
    end else if (bus.mul_req) begin
      pick = 1'b1;
    end
    sel_min  = pick ? bus.mul_Min  : bus.add_Min;
    sel_sign = pick ? bus.mul_sign : bus.add_sign;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; requests arriving while busy simply wait for IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registration at grant, result capture in ROUND, sticky flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.rnd_Min        <= '0;
      bus.rnd_sign       <= 1'b0;
      bus.rnd_roundMode  <= '0;
      cur                <= 1'b0;
      last_grant         <= 1'b1;
      bus.MOut           <= '0;
      bus.ovf_rnd        <= 1'b0;
      bus.inexact_flag   <= 1'b0;
      bus.owner          <= 1'b0;
      bus.inexact_sticky <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        bus.rnd_Min       <= sel_min;
        bus.rnd_sign      <= sel_sign;
        bus.rnd_roundMode <= sel_mode;
        cur               <= pick;
        last_grant        <= pick;
      end
      if (state == ROUND) begin
        bus.MOut         <= bus.rnd_MOut;
        bus.ovf_rnd      <= bus.rnd_ovf;
        bus.inexact_flag <= bus.rnd_inexact;
        bus.owner        <= cur;
      end
      if (state == ROUND && bus.rnd_inexact) begin
        bus.inexact_sticky <= 1'b1;
      end else if (bus.clr_sticky) begin
        bus.inexact_sticky <= 1'b0;
      end
    end
  end

  // Pulses decoded from state; cur and owner keep the pairs mutually exclusive.
  always_comb begin
    bus.add_gnt  = (state == ROUND) && !cur;
    bus.mul_gnt  = (state == ROUND) &&  cur;
    bus.add_done = (state == DONE)  && !bus.owner;
    bus.mul_done = (state == DONE)  &&  bus.owner;
    bus.busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_round_arbiter.sv
// Directed bench for round_arbiter with a scoreboard of expected results
// and a behavioural model of the shared rounder on the rnd_* ports.
module tb_round_arbiter;

  localparam int SW = 23;
  localparam int RW = 2;

  typedef struct packed {
    logic          who;
    logic [SW-1:0] m;
    logic          ovf;
    logic          inx;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];

  round_arbiter_if #(.Significant_WD(SW), .roundmodeReg_WD(RW)) bus();

  round_arbiter #(.Significant_WD(SW), .roundmodeReg_WD(RW)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Shared rounder: 1.mant + G,R,S guard bits, four IEEE-style modes.
  logic [SW:0]   r_m;
  logic [2:0]    r_g;
  logic          r_up;
  logic [SW+1:0] r_sum;
  always_comb begin
    r_m  = bus.rnd_Min[SW+3:3];
    r_g  = bus.rnd_Min[2:0];
    r_up = 1'b0;
    case (bus.rnd_roundMode)
      2'b00:   r_up = r_g[2] & (r_g[1] | r_g[0] | r_m[0]);
      2'b01:   r_up = 1'b0;
      2'b10:   r_up = ~bus.rnd_sign & (r_g != 3'b000);
      default: r_up =  bus.rnd_sign & (r_g != 3'b000);
    endcase
    r_sum = {1'b0, r_m} + (SW+2)'(r_up);
  end
  assign bus.rnd_MOut    = r_sum[SW-1:0];
  assign bus.rnd_ovf     = r_sum[SW+1];
  assign bus.rnd_inexact = |r_g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {2'b00, bus.add_gnt, bus.mul_gnt, bus.add_done, bus.mul_done,
            bus.rnd_Min, bus.rnd_roundMode, bus.rnd_sign, bus.MOut,
            bus.ovf_rnd, bus.inexact_flag, bus.owner, bus.busy, bus.inexact_sticky};
  endfunction

  // Monitor: pops one expected result per done pulse, checks exclusivity.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.add_gnt || bus.mul_gnt)
        check("gnt_exclusive", 64'(bus.add_gnt & bus.mul_gnt), 64'd0);
      if (bus.add_done || bus.mul_done) begin
        check("done_exclusive", 64'(bus.add_done & bus.mul_done), 64'd0);
        if (q.size() == 0) begin
          check("unexpected_done", 64'(bus.add_done | bus.mul_done), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("done_who", 64'(bus.mul_done), 64'(e.who));
          check("owner",    64'(bus.owner), 64'(e.who));
          check("MOut",     64'(bus.MOut), 64'(e.m));
          check("ovf_rnd",  64'(bus.ovf_rnd), 64'(e.ovf));
          check("inexact",  64'(bus.inexact_flag), 64'(e.inx));
        end
      end
    end
  end

  // Single operation from IDLE: grant one cycle after sampling, done one later.
  task automatic run_op(input logic who, input logic [SW+3:0] min, input logic sgn,
                        input logic [RW-1:0] mode, input exp_t e);
    int n;
    logic seen;
    q.push_back(e);
    @(negedge CLK);
    bus.roundMode = mode;
    if (who) begin
      bus.mul_req = 1'b1; bus.mul_Min = min; bus.mul_sign = sgn;
    end else begin
      bus.add_req = 1'b1; bus.add_Min = min; bus.add_sign = sgn;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      tick();
      n++;
      seen = who ? bus.mul_gnt : bus.add_gnt;
    end
    check("gnt_latency", 64'(n), 64'd1);
    @(negedge CLK);
    bus.add_req = 1'b0;
    bus.mul_req = 1'b0;
    tick();
    check("done_latency", 64'(who ? bus.mul_done : bus.add_done), 64'd1);
    tick();
  endtask

  initial begin
    bus.add_req = 0; bus.add_Min = '0; bus.add_sign = 0;
    bus.mul_req = 0; bus.mul_Min = '0; bus.mul_sign = 0;
    bus.roundMode = '0; bus.clr_sticky = 0;

    // reset state
    #12;
    check("reset_outs", all_outs(), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("idle_outs", all_outs(), 64'd0);

    // adder-only, nearest-even tie rounds odd mantissa up
    run_op(1'b0, 27'h400000C, 1'b0, 2'b00, '{who:1'b0, m:23'h000002, ovf:1'b0, inx:1'b1});
    check("sticky_after_add", 64'(bus.inexact_sticky), 64'd1);
    // multiplier toward zero
    run_op(1'b1, 27'h7FFFFFF, 1'b0, 2'b01, '{who:1'b1, m:23'h7FFFFF, ovf:1'b0, inx:1'b1});
    // rounding overflow
    run_op(1'b0, 27'h7FFFFFC, 1'b0, 2'b00, '{who:1'b0, m:23'h000000, ovf:1'b1, inx:1'b1});
    // toward -inf, negative
    run_op(1'b1, 27'h4000009, 1'b1, 2'b11, '{who:1'b1, m:23'h000002, ovf:1'b0, inx:1'b1});

    // tie after reset: adder first, multiplier three cycles later
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    q.push_back('{who:1'b0, m:23'h000001, ovf:1'b0, inx:1'b0});
    q.push_back('{who:1'b1, m:23'h200001, ovf:1'b0, inx:1'b1});
    bus.roundMode = 2'b00;
    bus.add_req = 1; bus.add_Min = 27'h4000008; bus.add_sign = 0;
    bus.mul_req = 1; bus.mul_Min = 27'h5000005; bus.mul_sign = 0;
    tick();
    check("tie_add_gnt", 64'({bus.add_gnt, bus.mul_gnt}), 64'b10);
    tick();
    check("tie_add_done", 64'(bus.add_done), 64'd1);
    tick();
    check("tie_owner0", 64'({bus.owner, bus.busy}), 64'b00);
    tick();
    check("tie_mul_gnt", 64'({bus.add_gnt, bus.mul_gnt}), 64'b01);
    @(negedge CLK);
    bus.add_req = 0; bus.mul_req = 0;
    tick();
    check("tie_mul_done", 64'(bus.mul_done), 64'd1);
    tick();
    check("tie_owner1", 64'({bus.owner, bus.busy}), 64'b10);

    // mid-flight request and roundMode change after grant
    @(negedge CLK);
    q.push_back('{who:1'b0, m:23'h000002, ovf:1'b0, inx:1'b1});
    bus.roundMode = 2'b10;
    bus.add_req = 1; bus.add_Min = 27'h400000C; bus.add_sign = 0;
    tick();
    check("mf_add_gnt", 64'(bus.add_gnt), 64'd1);
    @(negedge CLK);
    q.push_back('{who:1'b1, m:23'h000001, ovf:1'b0, inx:1'b1});
    bus.add_req = 0;
    bus.mul_req = 1; bus.mul_Min = 27'h400000C; bus.mul_sign = 0;
    bus.roundMode = 2'b01;
    tick();
    check("mf_hold_done", 64'({bus.mul_gnt, bus.add_done}), 64'b01);
    tick();
    check("mf_hold_idle", 64'({bus.mul_gnt, bus.busy}), 64'b00);
    tick();
    check("mf_mul_gnt", 64'(bus.mul_gnt), 64'd1);
    @(negedge CLK);
    bus.mul_req = 0;
    tick();
    check("mf_mul_done", 64'(bus.mul_done), 64'd1);
    tick();

    // sticky: plain clear, then set-wins race, then clear on next cycle
    @(negedge CLK);
    bus.clr_sticky = 1;
    tick();
    check("sticky_clr", 64'(bus.inexact_sticky), 64'd0);
    @(negedge CLK);
    bus.clr_sticky = 0;
    q.push_back('{who:1'b0, m:23'h000002, ovf:1'b0, inx:1'b1});
    bus.roundMode = 2'b00;
    bus.add_req = 1; bus.add_Min = 27'h400000C; bus.add_sign = 0;
    tick();
    check("race_gnt", 64'(bus.add_gnt), 64'd1);
    @(negedge CLK);
    bus.add_req = 0;
    bus.clr_sticky = 1;
    tick();
    check("race_set_wins", 64'(bus.inexact_sticky), 64'd1);
    tick();
    check("race_clr_next", 64'(bus.inexact_sticky), 64'd0);
    @(negedge CLK);
    bus.clr_sticky = 0;

    // reset in ROUND: operation dropped, no done
    bus.add_req = 1; bus.add_Min = 27'h5000005; bus.add_sign = 0;
    tick();
    check("rst_mid_gnt", 64'(bus.add_gnt), 64'd1);
    @(negedge CLK);
    RST = 1'b1;
    bus.add_req = 0;
    #1;
    check("rst_mid_async", all_outs(), 64'd0);
    tick();
    check("rst_mid_outs", all_outs(), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    tick();
    tick();
    check("rst_mid_idle", 64'({bus.busy, bus.add_done, bus.mul_done}), 64'd0);
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
